// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver with byte strobe, framing-error strobe, character count and end-of-line pulse
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 4167,
  parameter logic [7:0] EOL_CHAR = 8'h0A
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        ser_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        line_done,
  output logic [15:0] char_count,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  state_t state, state_n;
  logic s1, rx_s, rx_d, tick, valid_n, ferr_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sr, sr_n;
  assign tick = cnt == 16'd1;
  assign busy = state != IDLE;
  // two-flop synchronizer plus a delayed copy for falling-edge detection; resets to idle-high
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) {s1, rx_s, rx_d} <= 3'b111;
    else {s1, rx_s, rx_d} <= {ser_rx, s1, rx_s};
  // receiver state, baud counter, bit index and shift register
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sr    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sr    <= sr_n;
    end
  // output strobes and captured byte, registered on the stop-bit sample
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      line_done  <= 1'b0;
      char_count <= '0;
    end else begin
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      line_done <= valid_n && sr == EOL_CHAR;
      if (valid_n) begin
        rx_data    <= sr;
        char_count <= char_count + 16'd1;
      end
    end
  // next-state logic: counter expiry is the cycle it would decrement to zero
  always_comb begin
    state_n = state;
    cnt_n   = tick ? FULL : cnt - 16'd1;
    idx_n   = idx;
    sr_n    = sr;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = cnt;
        if (rx_d && !rx_s) begin
          state_n = START;
          cnt_n   = HALF;
        end
      end
      START:
        if (tick) begin
          state_n = rx_s ? IDLE : DATA;
          idx_n   = '0;
        end
      DATA:
        if (tick) begin
          sr_n[idx] = rx_s;
          idx_n     = idx + 3'd1;
          state_n   = idx == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (tick) begin
          state_n = rx_s ? IDLE : WAIT_IDLE;
          valid_n = rx_s;
          ferr_n  = !rx_s;
        end
      WAIT_IDLE: begin
        cnt_n = cnt;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: randomized self-checking bench for uart_rx_monitor against a frame-level reference model
module tb_uart_rx_monitor;
  localparam int CPB = 8;
  localparam int BIG = 4167;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
  localparam int LAT_BIG = 2 + BIG / 2 + 9 * BIG + 1;
  typedef struct {logic [7:0] d; logic ld; logic [15:0] cnt; int t;} ev_t;
  logic clock = 1'b0, resetb = 1'b0, rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic [15:0] char_count_a, char_count_b;
  logic rx_valid_a, frame_err_a, line_done_a, busy_a;
  logic rx_valid_b, frame_err_b, line_done_b, busy_b;
  logic pva = 1'b0, pfa = 1'b0, pvb = 1'b0, pfb = 1'b0;
  int cyc = 0, checks = 0, failures = 0, proto_a = 0, proto_b = 0, exp_cnt = 0, fall_b = 0;
  logic [7:0] exp_data = 8'h00;
  ev_t ev_a[$], ev_b[$];
  int ferr_a[$], ferr_b[$], fall_q[$];

  uart_rx_monitor #(.CLKS_PER_BIT(CPB)) dut_a (
    .clock(clock), .resetb(resetb), .ser_rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .frame_err(frame_err_a), .line_done(line_done_a), .char_count(char_count_a), .busy(busy_a));
  uart_rx_monitor dut_b (
    .clock(clock), .resetb(resetb), .ser_rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .frame_err(frame_err_b), .line_done(line_done_b), .char_count(char_count_b), .busy(busy_b));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_valid_a) ev_a.push_back(ev_t'{rx_data_a, line_done_a, char_count_a, cyc});
    if (frame_err_a) ferr_a.push_back(cyc);
    if ((rx_valid_a && (frame_err_a || pva)) || (frame_err_a && pfa) || (line_done_a && !rx_valid_a)) proto_a++;
    pva = rx_valid_a;
    pfa = frame_err_a;
    if (rx_valid_b) ev_b.push_back(ev_t'{rx_data_b, line_done_b, char_count_b, cyc});
    if (frame_err_b) ferr_b.push_back(cyc);
    if ((rx_valid_b && (frame_err_b || pvb)) || (frame_err_b && pfb) || (line_done_b && !rx_valid_b)) proto_b++;
    pvb = rx_valid_b;
    pfb = frame_err_b;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit big, input logic v);
    if (big) rx_b = v;
    else rx_a = v;
  endtask

  task automatic clear();
    ev_a.delete();
    ev_b.delete();
    ferr_a.delete();
    ferr_b.delete();
    fall_q.delete();
  endtask

  task automatic send_frame(input bit big, input logic [7:0] d, input logic stop);
    int cpb = big ? BIG : CPB;
    logic [9:0] f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(big, f[i]);
      if (i == 0 && big) fall_b = cyc;
      if (i == 0 && !big) fall_q.push_back(cyc);
      idle(cpb);
    end
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (rx_data_a !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h want=00", rx_data_a); end
    checks++; if ({rx_valid_a, frame_err_a, line_done_a, busy_a} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b want=0000", {rx_valid_a, frame_err_a, line_done_a, busy_a}); end
    checks++; if (char_count_a !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h want=0000", char_count_a); end
    checks++; if ({rx_valid_b, busy_b, char_count_b} !== 18'h0) begin failures++; $display("FAIL reset_b got=%h want=0", {rx_valid_b, busy_b, char_count_b}); end
    resetb = 1'b1;
    clear();
    idle(5);
    checks++; if (busy_a !== 1'b0 || ev_a.size() != 0) begin failures++; $display("FAIL reset_idle busy=%b events=%0d want busy=0 events=0", busy_a, ev_a.size()); end
  endtask

  task automatic test_single();
    clear();
    send_frame(0, 8'h41, 1'b1);
    idle(4);
    exp_cnt++;
    exp_data = 8'h41;
    checks++; if (ev_a.size() != 1) begin failures++; $display("FAIL single_count_strobes got=%0d want=1", ev_a.size()); end
    if (ev_a.size() >= 1) begin
      checks++; if (ev_a[0].d !== 8'h41) begin failures++; $display("FAIL single_data got=%h want=41", ev_a[0].d); end
      checks++; if (ev_a[0].cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL single_char_count got=%0d want=%0d", ev_a[0].cnt, exp_cnt); end
      checks++; if (ev_a[0].ld !== 1'b0) begin failures++; $display("FAIL single_line_done got=%b want=0", ev_a[0].ld); end
      checks++; if (ev_a[0].t - fall_q[0] != LAT) begin failures++; $display("FAIL single_latency got=%0d want=%0d", ev_a[0].t - fall_q[0], LAT); end
    end
    checks++; if (ferr_a.size() != 0) begin failures++; $display("FAIL single_frame_err got=%0d want=0", ferr_a.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[$];
    int base = exp_cnt;
    msg = '{8'h4C, 8'h41, 8'h0A};
    for (int i = 0; i < 6; i++) msg.push_back(($urandom % 4 == 0) ? 8'h0A : 8'($urandom_range(0, 255)));
    clear();
    foreach (msg[i]) send_frame(0, msg[i], 1'b1);
    idle(4);
    exp_cnt += msg.size();
    exp_data = msg[msg.size() - 1];
    checks++; if (ev_a.size() != msg.size()) begin failures++; $display("FAIL b2b_strobes got=%0d want=%0d", ev_a.size(), msg.size()); end
    for (int i = 0; i < ev_a.size() && i < msg.size(); i++) begin
      checks++; if (ev_a[i].d !== msg[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, ev_a[i].d, msg[i]); end
      checks++; if (ev_a[i].ld !== (msg[i] == 8'h0A)) begin failures++; $display("FAIL b2b_line_done[%0d] got=%b want=%b", i, ev_a[i].ld, msg[i] == 8'h0A); end
      checks++; if (ev_a[i].cnt !== 16'(base + i + 1)) begin failures++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", i, ev_a[i].cnt, base + i + 1); end
      checks++; if (ev_a[i].t - fall_q[i] != LAT) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, ev_a[i].t - fall_q[i], LAT); end
    end
    checks++; if (ferr_a.size() != 0) begin failures++; $display("FAIL b2b_frame_err got=%0d want=0", ferr_a.size()); end
  endtask

  task automatic test_glitch();
    bit seen = 1'b0;
    int t0;
    clear();
    drive(0, 1'b0);
    t0 = cyc;
    idle(2);
    drive(0, 1'b1);
    for (int i = 0; i < 64 && cyc < t0 + CPB / 2 + 3; i++) begin
      @(negedge clock);
      if (busy_a) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%b want=1", seen); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop got=%b want=0", busy_a); end
    idle(12 * CPB);
    checks++; if (ev_a.size() + ferr_a.size() != 0) begin failures++; $display("FAIL glitch_strobe got=%0d want=0", ev_a.size() + ferr_a.size()); end
    checks++; if (char_count_a !== 16'(exp_cnt)) begin failures++; $display("FAIL glitch_count got=%0d want=%0d", char_count_a, exp_cnt); end
  endtask

  task automatic test_frame_err();
    clear();
    send_frame(0, 8'h55, 1'b0);
    idle(30);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL ferr_wait_idle_busy got=%b want=1", busy_a); end
    drive(0, 1'b1);
    idle(4);
    checks++; if (ferr_a.size() != 1) begin failures++; $display("FAIL ferr_pulses got=%0d want=1", ferr_a.size()); end
    if (ferr_a.size() >= 1) begin
      checks++; if (ferr_a[0] - fall_q[0] != LAT) begin failures++; $display("FAIL ferr_latency got=%0d want=%0d", ferr_a[0] - fall_q[0], LAT); end
    end
    checks++; if (ev_a.size() != 0) begin failures++; $display("FAIL ferr_valid got=%0d want=0", ev_a.size()); end
    checks++; if (rx_data_a !== exp_data) begin failures++; $display("FAIL ferr_rx_data_held got=%h want=%h", rx_data_a, exp_data); end
    checks++; if (char_count_a !== 16'(exp_cnt)) begin failures++; $display("FAIL ferr_count_held got=%0d want=%0d", char_count_a, exp_cnt); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL ferr_back_idle got=%b want=0", busy_a); end
    send_frame(0, 8'h33, 1'b1);
    idle(4);
    exp_cnt++;
    exp_data = 8'h33;
    checks++; if (ev_a.size() != 1) begin failures++; $display("FAIL ferr_next_strobes got=%0d want=1", ev_a.size()); end
    if (ev_a.size() >= 1) begin
      checks++; if (ev_a[0].d !== 8'h33 || ev_a[0].cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL ferr_next_byte got=%h/%0d want=33/%0d", ev_a[0].d, ev_a[0].cnt, exp_cnt); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d = 8'($urandom_range(0, 255));
    clear();
    drive(0, 1'b0);
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      drive(0, d[i]);
      idle(CPB);
    end
    drive(0, d[4]);
    idle(CPB / 2);
    resetb = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0 || char_count_a !== 16'h0) begin failures++; $display("FAIL midrst_async got=%b/%0d want=0/0", busy_a, char_count_a); end
    idle(2);
    drive(0, 1'b1);
    idle(2);
    resetb = 1'b1;
    exp_cnt = 0;
    idle(12 * CPB);
    checks++; if (ev_a.size() + ferr_a.size() != 0) begin failures++; $display("FAIL midrst_partial_strobe got=%0d want=0", ev_a.size() + ferr_a.size()); end
    clear();
    send_frame(0, 8'hA5, 1'b1);
    idle(4);
    exp_cnt++;
    exp_data = 8'hA5;
    checks++; if (ev_a.size() != 1) begin failures++; $display("FAIL midrst_strobes got=%0d want=1", ev_a.size()); end
    if (ev_a.size() >= 1) begin
      checks++; if (ev_a[0].d !== 8'hA5 || ev_a[0].cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL midrst_byte got=%h/%0d want=a5/%0d", ev_a[0].d, ev_a[0].cnt, exp_cnt); end
    end
  endtask

  task automatic test_low_at_release();
    resetb = 1'b0;
    drive(0, 1'b0);
    idle(2);
    clear();
    resetb = 1'b1;
    exp_cnt = 0;
    idle(11 * CPB);
    checks++; if (ferr_a.size() != 1 || ev_a.size() != 0) begin failures++; $display("FAIL lowrel_strobes got ferr=%0d valid=%0d want ferr=1 valid=0", ferr_a.size(), ev_a.size()); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL lowrel_wait_idle got=%b want=1", busy_a); end
    drive(0, 1'b1);
    idle(4);
    checks++; if (busy_a !== 1'b0 || char_count_a !== 16'h0) begin failures++; $display("FAIL lowrel_recover got=%b/%0d want=0/0", busy_a, char_count_a); end
  endtask

  task automatic test_default_baud();
    clear();
    send_frame(1, 8'h0A, 1'b1);
    idle(10);
    checks++; if (ev_b.size() != 1) begin failures++; $display("FAIL baud_strobes got=%0d want=1", ev_b.size()); end
    if (ev_b.size() >= 1) begin
      checks++; if (ev_b[0].d !== 8'h0A || ev_b[0].ld !== 1'b1) begin failures++; $display("FAIL baud_byte got=%h ld=%b want=0a ld=1", ev_b[0].d, ev_b[0].ld); end
      checks++; if (ev_b[0].cnt !== 16'd1) begin failures++; $display("FAIL baud_count got=%0d want=1", ev_b[0].cnt); end
      checks++; if (ev_b[0].t - fall_b != LAT_BIG) begin failures++; $display("FAIL baud_latency got=%0d want=%0d", ev_b[0].t - fall_b, LAT_BIG); end
    end
    checks++; if (ferr_b.size() != 0) begin failures++; $display("FAIL baud_frame_err got=%0d want=0", ferr_b.size()); end
  endtask

  task automatic test_protocol();
    checks++; if (proto_a != 0) begin failures++; $display("FAIL strobe_rules_a got=%0d want=0", proto_a); end
    checks++; if (proto_b != 0) begin failures++; $display("FAIL strobe_rules_b got=%0d want=0", proto_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_low_at_release();
    test_default_baud();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
